// File: rtl/mem_burst_ctrl.sv
// Line-burst memory controller: 8192 blocks x 16 words, 16-beat fills and write-backs
// separated from the request/response by a fixed LATENCY of idle cycles.
module mem_burst_ctrl #(
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [12:0] req_block,
   input  logic [31:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        rd_last,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_BURST = 3'd2,
      WR_BURST = 3'd3,
      WR_WAIT  = 3'd4
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [3:0]  wait_r;
   logic [12:0] blk_r;
   logic        req_ready_r;
   logic        wr_ready_r;
   logic [31:0] rd_data_r;
   logic        rd_valid_r;
   logic        rd_last_r;
   logic        busy_r;

   logic [31:0] mem_r [0:131071];
   logic [3:0]  rd_idx_s;
   logic [31:0] rd_word_s;
   logic        wr_en_s;

   // Words are stored XOR their index, so a zero-initialised array reads back j at word j.
   function automatic logic [31:0] word_code(input logic [31:0] w, input logic [3:0] idx);
      return w ^ {28'd0, idx};
   endfunction

   // Next fill word: word 0 while waiting, cnt+1 during the burst.
   always_comb begin
      rd_idx_s  = (state_r == RD_BURST) ? (cnt_r + 4'd1) : 4'd0;
      rd_word_s = word_code(mem_r[{blk_r, rd_idx_s}], rd_idx_s);
      wr_en_s   = (state_r == WR_BURST) && wr_valid;
   end

   // Storage write port; deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[{blk_r, cnt_r}] <= word_code(wr_data, cnt_r);
      end
   end

   // Burst FSM with registered handshake and read outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         wait_r      <= 4'd0;
         blk_r       <= 13'd0;
         req_ready_r <= 1'b1;
         wr_ready_r  <= 1'b0;
         rd_data_r   <= 32'd0;
         rd_valid_r  <= 1'b0;
         rd_last_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  blk_r       <= req_block;
                  cnt_r       <= 4'd0;
                  wait_r      <= 4'd0;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (req_write) begin
                     state_r    <= WR_BURST;
                     wr_ready_r <= 1'b1;
                  end else begin
                     state_r <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (wait_r == LAT_M1) begin
                  state_r    <= RD_BURST;
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= rd_word_s;
                  rd_last_r  <= 1'b0;
               end else begin
                  wait_r <= wait_r + 4'd1;
               end
            end
            RD_BURST: begin
               if (cnt_r == 4'd15) begin
                  state_r     <= IDLE;
                  cnt_r       <= 4'd0;
                  rd_valid_r  <= 1'b0;
                  rd_last_r   <= 1'b0;
                  rd_data_r   <= 32'd0;
                  req_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  cnt_r     <= cnt_r + 4'd1;
                  rd_data_r <= rd_word_s;
                  rd_last_r <= (cnt_r == 4'd14);
               end
            end
            WR_BURST: begin
               if (wr_valid) begin
                  cnt_r <= cnt_r + 4'd1;
                  if (cnt_r == 4'd15) begin
                     state_r    <= WR_WAIT;
                     wr_ready_r <= 1'b0;
                     wait_r     <= 4'd0;
                  end
               end
            end
            WR_WAIT: begin
               if (wait_r == LAT_M1) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  wait_r <= wait_r + 4'd1;
               end
            end
            default: begin
               state_r     <= IDLE;
               cnt_r       <= 4'd0;
               wait_r      <= 4'd0;
               req_ready_r <= 1'b1;
               wr_ready_r  <= 1'b0;
               rd_data_r   <= 32'd0;
               rd_valid_r  <= 1'b0;
               rd_last_r   <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign wr_ready  = wr_ready_r;
   assign rd_data   = rd_data_r;
   assign rd_valid  = rd_valid_r;
   assign rd_last   = rd_last_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: fill words are predicted from a storage model and
// queued at request time, then popped and compared as the burst streams out.
module tb_mem_burst_ctrl;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [12:0] req_block = 13'd0;
   logic [31:0] wr_data = 32'd0;
   logic        wr_valid = 1'b0;
   logic        req_ready, wr_ready, rd_valid, rd_last, busy;
   logic [31:0] rd_data;

   logic        rv_1 = 1'b0, rv_15 = 1'b0;
   logic        rr_1, wrr_1, rdv_1, rdl_1, bsy_1;
   logic        rr_15, wrr_15, rdv_15, rdl_15, bsy_15;
   logic [31:0] rdd_1, rdd_15;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model_mem [int];

   mem_burst_ctrl #(.LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_block(req_block), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy));

   mem_burst_ctrl #(.LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .req_valid(rv_1), .req_ready(rr_1),
      .req_write(req_write), .req_block(req_block), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wrr_1), .rd_data(rdd_1),
      .rd_valid(rdv_1), .rd_last(rdl_1), .busy(bsy_1));

   mem_burst_ctrl #(.LATENCY(15)) dut_l15 (
      .clk(clk), .reset(reset), .req_valid(rv_15), .req_ready(rr_15),
      .req_write(req_write), .req_block(req_block), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wrr_15), .rd_data(rdd_15),
      .rd_valid(rdv_15), .rd_last(rdl_15), .busy(bsy_15));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input int blk, input int j);
      int key;
      key = blk * 16 + j;
      if (model_mem.exists(key)) return model_mem[key];
      else return 32'(j);
   endfunction

   // Assert reset in the middle of a cycle and expect all outputs to collapse at once.
   task automatic mid_reset(input string tag);
      #3;
      reset = 1'b1;
      #1;
      check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      check({tag, "_rd_data"}, rd_data, 32'd0);
      check({tag, "_rd_last"}, {31'd0, rd_last}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
      exp_q.delete();
      tick();
      reset = 1'b0;
   endtask

   // Fill of blk; optionally hold a second request during it, or abort after 'abort_at' words.
   task automatic fill(input logic [12:0] blk, input bit hold, input logic [12:0] hold_blk,
                       input int abort_at, input string tag);
      int k;
      logic [31:0] exp;
      for (int j = 0; j < 16; j++) exp_q.push_back(model_rd(int'(blk), j));
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_block = blk;
      tick();
      req_valid = hold;
      req_block = hold ? hold_blk : blk;
      k = 0;
      while (!rd_valid && k < 40) begin
         if (hold) check({tag, "_hold_ready_wait"}, {31'd0, req_ready}, 32'd0);
         tick();
         k++;
      end
      // rd_valid becomes visible after edge N+LATENCY, i.e. during cycle N+LATENCY+1
      check({tag, "_latency"}, 32'(k), 32'(LAT));
      for (int j = 0; j < 16; j++) begin
         if (j == abort_at) begin
            mid_reset({tag, "_abort"});
            return;
         end
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'bx;
         check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
         check({tag, "_rd_data"}, rd_data, exp);
         check({tag, "_rd_last"}, {31'd0, rd_last}, (j == 15) ? 32'd1 : 32'd0);
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         if (hold) check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
         tick();
      end
      check({tag, "_end_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      check({tag, "_end_rd_data"}, rd_data, 32'd0);
      check({tag, "_end_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Write-back of n_words (16 = complete burst) with a 3-cycle wr_valid gap before word stall_at.
   task automatic wr_burst(input logic [12:0] blk, input logic [31:0] base, input int stall_at,
                           input int n_words, input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_block = blk;
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      for (int i = 0; i < n_words; i++) begin
         if (i == stall_at) begin
            wr_valid = 1'b0;
            for (int s = 0; s < 3; s++) begin
               check({tag, "_stall_wr_ready"}, {31'd0, wr_ready}, 32'd1);
               tick();
            end
         end
         check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         wr_valid = 1'b1;
         wr_data = base + 32'(i);
         model_mem[int'(blk) * 16 + i] = base + 32'(i);
         tick();
      end
      if (n_words == 16) begin
         wr_data = 32'hDEAD_BEEF;
         for (int c = 0; c < LAT; c++) begin
            check({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_wait_wr_ready"}, {31'd0, wr_ready}, 32'd0);
            tick();
         end
         check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
         check({tag, "_done_req_ready"}, {31'd0, req_ready}, 32'd1);
      end
      wr_valid = 1'b0;
   endtask

   initial begin
      int k1, k15;
      repeat (2) tick();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_rd_last", {31'd0, rd_last}, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      fill(13'h1A3, 1'b0, 13'd0, 16, "fill_1a3");

      // Latency extremes on the side instances.
      rv_1 = 1'b1;
      rv_15 = 1'b1;
      req_block = 13'h1A3;
      tick();
      rv_1 = 1'b0;
      rv_15 = 1'b0;
      k1 = 0;
      k15 = 0;
      for (int c = 1; c <= 40; c++) begin
         if (rdv_1 && k1 == 0) begin
            k1 = c - 1;
            check("lat1_first_word", rdd_1, 32'd0);
         end
         if (rdv_15 && k15 == 0) begin
            k15 = c - 1;
            check("lat15_first_word", rdd_15, 32'd0);
         end
         tick();
      end
      check("lat1_latency", 32'(k1), 32'd1);
      check("lat15_latency", 32'(k15), 32'd15);

      wr_burst(13'h1FFF, 32'hA0, 5, 16, "wb_1fff");
      fill(13'h1FFF, 1'b1, 13'h0005, 16, "fill_1fff_hold");
      fill(13'h0005, 1'b0, 13'd0, 16, "fill_held_0005");

      fill(13'h0000, 1'b0, 13'd0, 8, "fill_0_abort");
      fill(13'h0000, 1'b0, 13'd0, 16, "fill_0_after_rst");

      wr_burst(13'h0042, 32'hB0, 99, 8, "wb_0042_part");
      mid_reset("wb_abort");
      fill(13'h0042, 1'b0, 13'd0, 16, "fill_0042");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the idle cycles between request acceptance and first read word, and after the last write word; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  cache presents a line request.
REQ-005 req_ready  output  1  controller accepts the request this cycle.
REQ-006 req_write  input  1  1 = line write-back, 0 = line fill; sampled on acceptance.
REQ-007 req_block  input  13  main-memory block index {tag, cache line}; sampled on acceptance.
REQ-008 wr_data  input  32  write-back word.
REQ-009 wr_valid  input  1  wr_data is valid.
REQ-010 wr_ready  output  1  controller accepts wr_data this cycle.
REQ-011 rd_data  output  32  fill word.
REQ-012 rd_valid  output  1  rd_data is valid; no back-pressure.
REQ-013 rd_last  output  1  marks the 16th fill word.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Storage SHALL be 8192 blocks x 16 words x 32 bits, with word j of every block initialised to j at time zero; reset SHALL NOT alter storage.
REQ-016 The FSM SHALL have states IDLE, RD_WAIT, RD_BURST, WR_BURST and WR_WAIT.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance is req_valid & req_ready at a rising edge.
REQ-018 Acceptance SHALL register req_block, clear the 4-bit word counter and go to RD_WAIT (req_write=0) or WR_BURST (req_write=1).
REQ-019 RD_WAIT SHALL last exactly LATENCY cycles and then enter RD_BURST.
REQ-020 RD_BURST SHALL drive rd_valid=1 for 16 consecutive cycles with rd_data = mem[block][cnt], cnt = 0..15 ascending; rd_last=1 only when cnt=15.
REQ-021 For acceptance at edge N, rd_valid SHALL be high in cycles N+LATENCY+1 through N+LATENCY+16, with IDLE re-entered at the following edge.
REQ-022 WR_BURST SHALL drive wr_ready=1; each wr_valid & wr_ready edge SHALL write wr_data to mem[block][cnt] and increment cnt.
REQ-023 wr_valid low in WR_BURST SHALL stall with no write and no cnt change; there is no timeout.
REQ-024 The write at cnt=15 SHALL wrap cnt to 0 and enter WR_WAIT.
REQ-025 WR_WAIT SHALL hold wr_ready=0 for LATENCY cycles and then return to IDLE.
REQ-026 A read SHALL return values from all prior completed write bursts (one outstanding request, in-order).
REQ-027 wr_valid outside WR_BURST SHALL be ignored; req_valid outside IDLE SHALL be ignored and held by the requester.
REQ-028 rd_data SHALL be 0 whenever rd_valid=0.
REQ-029 busy SHALL equal ~req_ready.

Reset
REQ-030 While reset is high: state=IDLE, cnt=0, registered block=0, req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0; this takes effect asynchronously.
REQ-031 Reset during any burst SHALL abort it: words already written remain in storage, remaining fill words are never driven, and no write-back completes later.
REQ-032 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 Fill after reset, LATENCY=4, block 0x1A3 accepted at edge N -> rd_valid high in cycles N+5..N+20, data 0..15, rd_last only with data 15.
REQ-034 Write-back to block 0x1FFF with data 0xA0..0xAF, wr_valid low for 3 cycles after word 5 -> wr_ready stays high, exactly 16 writes occur, then busy is high for 4 more cycles. A following fill of 0x1FFF returns 0xA0..0xAF.
REQ-035 req_valid held high during a fill with a different block -> req_ready stays 0 and the second request is accepted only in the cycle after rd_last.
REQ-036 Reset asserted mid-cycle after the 8th fill word -> rd_valid drops immediately, busy=0, and a new fill of block 0 returns 0..15 in full.
REQ-037 Reset after 8 of 16 write words to block 0x0042 (data 0xB0..) -> a fill returns 0xB0..0xB7 followed by 8..15.
REQ-038 LATENCY=1 and LATENCY=15 builds, fill accepted at edge N -> first rd_valid at N+2 and at N+16 respectively.
